// File: rtl/i2s_record_ctrl_pkg.sv
// Shared types for the I2S recording controller: session FSM encoding and
// the bytes-per-sample helper used to size the serializer.
package i2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } rec_state_t;

  function automatic int BYTES_PER_SAMPLE(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/i2s_record_ctrl_if.sv
// PCM sample strobe from the microphone front end and byte write port to
// the capture FIFO, bundled as one bus seen from the controller (master).
interface i2s_record_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] pcm_in;
  logic              pcm_valid;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [7:0]        fifo_wr_data;

  modport master (
    input  pcm_in, pcm_valid, fifo_full,
    output fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output pcm_in, pcm_valid, fifo_full,
    input  fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/i2s_record_ctrl_serializer.sv
// MSB-first byte serializer: loads a PCM sample, presents its top byte and
// shifts one byte per accepted FIFO write; last flags the final byte.
module sample_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        byte_out,
  output logic              last
);
  localparam int NB    = BYTES_PER_SAMPLE(DATA_W);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= din;
      idx   <= '0;
    end else if (advance) begin
      shreg <= shreg << 8;
      idx   <= idx + 1'b1;
    end
  end

  assign byte_out = shreg[DATA_W-1 -: 8];
  assign last     = (idx == IDX_LAST);

endmodule

// File: rtl/i2s_record_ctrl.sv
// Recording-session controller: warm-up discard, per-sample serialization
// into the byte FIFO, sample counting, stop handling and overflow flagging.
module i2s_record_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int COUNT_W        = 24,
  parameter int WARMUP_SAMPLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [COUNT_W-1:0] sample_count,
  i2s_record_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [COUNT_W-1:0] captured
);
  localparam int WU_W = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);

  rec_state_t         state, state_d;
  logic [COUNT_W-1:0] target;
  logic [WU_W-1:0]    wu_cnt;
  logic               stop_pending;
  logic               ser_load;
  logic               ser_last;
  logic               byte_acc;
  logic               last_acc;
  logic               end_hit;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sample_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .advance  (byte_acc),
    .din      (bus.pcm_in),
    .byte_out (bus.fifo_wr_data),
    .last     (ser_last)
  );

  assign byte_acc       = (state == ST_WRITE) && !bus.fifo_full;
  assign last_acc       = byte_acc && ser_last;
  assign bus.fifo_wr_en = byte_acc;
  assign end_hit        = (target != '0) && (captured + 1'b1 == target);

  always_comb begin
    state_d  = state;
    ser_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_d = (WARMUP_SAMPLES == 0) ? ST_CAPTURE : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (stop)                                   state_d = ST_DONE;
        else if (bus.pcm_valid && wu_cnt == WU_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (bus.pcm_valid) begin
          state_d  = ST_WRITE;
          ser_load = 1'b1;
        end
      end
      ST_WRITE: begin
        // A stop arriving on the final byte counts the same as a pending one.
        if (last_acc) state_d = (end_hit || stop_pending || stop) ? ST_DONE : ST_CAPTURE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      target       <= '0;
      captured     <= '0;
      overflow     <= 1'b0;
      stop_pending <= 1'b0;
      wu_cnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != ST_IDLE);
      done  <= (state_d == ST_DONE);
      if (state == ST_IDLE && start) begin
        target   <= sample_count;
        captured <= '0;
        overflow <= 1'b0;
        wu_cnt   <= '0;
      end
      if (state == ST_WARMUP && bus.pcm_valid) wu_cnt <= wu_cnt + 1'b1;
      if (last_acc) captured <= sat_inc(captured);
      if (state == ST_WRITE && bus.pcm_valid) overflow <= 1'b1;
      if (state == ST_WRITE && stop)      stop_pending <= 1'b1;
      else if (state == ST_DONE)          stop_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_record_ctrl.sv
// Scoreboard bench: stimulus pushes expected FIFO bytes, a negedge monitor
// pops and compares every accepted write and checks done timing.
module tb_i2s_record_ctrl;
  import i2s_pkg::*;

  localparam int DATA_W  = 16;
  localparam int COUNT_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, start, stop, busy, done, overflow;
  logic [COUNT_W-1:0] sample_count, captured;
  logic               start4, stop4, busy4, done4, overflow4;
  logic [COUNT_W-1:0] count4, captured4;

  i2s_record_ctrl_if #(.DATA_W(DATA_W)) bus0 ();
  i2s_record_ctrl_if #(.DATA_W(DATA_W)) bus4 ();

  i2s_record_ctrl #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .WARMUP_SAMPLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample_count(sample_count),
    .bus(bus0), .busy(busy), .done(done), .overflow(overflow), .captured(captured)
  );

  i2s_record_ctrl #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .WARMUP_SAMPLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .sample_count(count4),
    .bus(bus4), .busy(busy4), .done(done4), .overflow(overflow4), .captured(captured4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wr0 = -10;
  int last_wr4 = -10;
  int done_cnt0 = 0;
  int done_cnt4 = 0;
  int d0;
  logic [7:0] q0[$];
  logic [7:0] q4[$];
  int wr_cyc0[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus0.fifo_wr_en) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected0: got byte %0h expected no write", bus0.fifo_wr_data);
      end else begin
        check("wr_byte0", bus0.fifo_wr_data, q0.pop_front());
      end
      last_wr0 = cyc;
      wr_cyc0.push_back(cyc);
    end
    if (rst_n && bus4.fifo_wr_en) begin
      if (q4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected4: got byte %0h expected no write", bus4.fifo_wr_data);
      end else begin
        check("wr_byte4", bus4.fifo_wr_data, q4.pop_front());
      end
      last_wr4 = cyc;
    end
    if (rst_n && done) begin
      done_cnt0++;
      check("done_after_wr0", cyc - last_wr0, 1);
    end
    if (rst_n && done4) begin
      done_cnt4++;
      check("done_after_wr4", cyc - last_wr4, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start0(input logic [COUNT_W-1:0] c);
    start = 1'b1; sample_count = c;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send0(input logic [15:0] d);
    bus0.pcm_in = d; bus0.pcm_valid = 1'b1;
    q0.push_back(d[15:8]); q0.push_back(d[7:0]);
    tick(1);
    bus0.pcm_valid = 1'b0;
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_count = '0;
    start4 = 1'b0; stop4 = 1'b0; count4 = '0;
    bus0.pcm_in = '0; bus0.pcm_valid = 1'b0; bus0.fifo_full = 1'b0;
    bus4.pcm_in = '0; bus4.pcm_valid = 1'b0; bus4.fifo_full = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_wr_en", bus0.fifo_wr_en, 0);
    check("rst_wr_data", bus0.fifo_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_captured", captured, 0);

    // count stop, no warm-up
    d0 = done_cnt0;
    start0(3);
    check("t1_busy_after_start", busy, 1);
    send0(16'h1234);
    send0(16'hABCD);
    send0(16'h00FF);
    check("t1_captured", captured, 3);
    check("t1_overflow", overflow, 0);
    check("t1_busy_end", busy, 0);
    check("t1_done_cnt", done_cnt0 - d0, 1);

    // warm-up discard on the WARMUP_SAMPLES=4 instance
    start4 = 1'b1; count4 = 2;
    tick(1);
    start4 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus4.pcm_in = 16'(i); bus4.pcm_valid = 1'b1;
      if (i >= 5) begin q4.push_back(8'h00); q4.push_back(8'(i)); end
      tick(1);
      bus4.pcm_valid = 1'b0;
      tick(3);
    end
    check("t2_captured", captured4, 2);
    check("t2_overflow", overflow4, 0);
    check("t2_busy_end", busy4, 0);
    check("t2_done_cnt", done_cnt4, 1);

    // backpressure: five full cycles on byte 1
    start0(1);
    bus0.pcm_in = 16'hBEEF; bus0.pcm_valid = 1'b1;
    q0.push_back(8'hBE); q0.push_back(8'hEF);
    tick(1);
    bus0.pcm_valid = 1'b0;
    tick(1);
    bus0.fifo_full = 1'b1;
    tick(5);
    bus0.fifo_full = 1'b0;
    tick(3);
    check("t3_byte_gap", wr_cyc0[wr_cyc0.size()-1] - wr_cyc0[wr_cyc0.size()-2], 6);
    check("t3_captured", captured, 1);

    // overflow: sample arriving while stalled in WRITE is dropped
    start0(2);
    bus0.fifo_full = 1'b1;
    bus0.pcm_in = 16'h1111; bus0.pcm_valid = 1'b1;
    q0.push_back(8'h11); q0.push_back(8'h11);
    tick(1);
    bus0.pcm_in = 16'h2222;
    tick(1);
    bus0.pcm_valid = 1'b0;
    check("t4_overflow_set", overflow, 1);
    bus0.fifo_full = 1'b0;
    tick(3);
    send0(16'h3333);
    check("t4_captured", captured, 2);
    check("t4_overflow_sticky", overflow, 1);
    check("t4_busy_end", busy, 0);

    // continuous mode, stop while byte 1 of sample 7 is stalled
    d0 = done_cnt0;
    start0(0);
    check("t5_overflow_cleared", overflow, 0);
    for (int i = 1; i <= 6; i++) send0(16'(16'h0101 * i));
    bus0.pcm_in = 16'h7A7B; bus0.pcm_valid = 1'b1;
    q0.push_back(8'h7A); q0.push_back(8'h7B);
    tick(1);
    bus0.pcm_valid = 1'b0;
    tick(1);
    bus0.fifo_full = 1'b1; stop = 1'b1;
    tick(1);
    stop = 1'b0; bus0.fifo_full = 1'b0;
    tick(3);
    check("t5_captured", captured, 7);
    check("t5_done_cnt", done_cnt0 - d0, 1);
    check("t5_busy_end", busy, 0);
    check("t5_q_empty", q0.size(), 0);

    // reset in the middle of a sample
    start0(5);
    send0(16'h0A0B);
    bus0.pcm_in = 16'hC0DE; bus0.pcm_valid = 1'b1;
    q0.push_back(8'hC0);
    tick(1);
    bus0.pcm_in = 16'h5555;
    tick(1);
    bus0.pcm_valid = 1'b0; bus0.fifo_full = 1'b1;
    tick(1);
    check("t6_pre_overflow", overflow, 1);
    check("t6_pre_captured", captured, 1);
    check("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; bus0.fifo_full = 1'b0;
    tick(1);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_overflow", overflow, 0);
    check("t6_captured", captured, 0);
    check("t6_wr_en", bus0.fifo_wr_en, 0);
    check("t6_wr_data", bus0.fifo_wr_data, 0);

    // start with stop in IDLE, then start ignored while busy
    d0 = done_cnt0;
    start = 1'b1; stop = 1'b1; sample_count = 3;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("t7_start_wins", busy, 1);
    tick(1);
    check("t7_still_busy", busy, 1);
    bus0.pcm_in = 16'h0102; bus0.pcm_valid = 1'b1;
    q0.push_back(8'h01); q0.push_back(8'h02);
    tick(1);
    bus0.pcm_in = 16'h9999;
    tick(1);
    bus0.pcm_valid = 1'b0;
    tick(2);
    check("t7_overflow", overflow, 1);
    check("t7_captured1", captured, 1);
    start0(2);
    check("t7_ign_busy", busy, 1);
    check("t7_ign_captured", captured, 1);
    check("t7_ign_overflow", overflow, 1);
    send0(16'h0304);
    check("t7_target_kept", busy, 1);
    check("t7_captured2", captured, 2);
    send0(16'h0506);
    check("t7_captured3", captured, 3);
    check("t7_busy_end", busy, 0);
    check("t7_done_cnt", done_cnt0 - d0, 1);

    tick(2);
    check("q0_drained", q0.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_record_ctrl.md
# i2s_record_ctrl

Recording-session controller between the PCM output of the I2S microphone front end (`pcm_out`/`pcm_ready`) and the byte-wide capture FIFO read out over SPI. It arms on a start command and discards a fixed number of microphone warm-up samples. It then serializes each accepted PCM sample MSB-first into the FIFO, counts samples, stops on target count or stop command, and flags dropped samples.

## Interface
- `DATA_W`, 16: PCM sample width; must be a multiple of 8.
- `COUNT_W`, 24: width of sample-count target and counter.
- `WARMUP_SAMPLES`, 4096: samples discarded after start; 0 disables warm-up.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; begins a session; ignored unless IDLE.
- `stop` in 1: one-cycle pulse; ends the session; ignored in IDLE.
- `sample_count` in COUNT_W: samples to record; sampled on accepted `start`; 0 = continuous until `stop`.
- `pcm_in` in DATA_W: PCM sample, valid only with `pcm_valid`.
- `pcm_valid` in 1: one-cycle sample strobe.
- `fifo_full` in 1: FIFO cannot accept a byte this cycle.
- `fifo_wr_en` out 1: byte write strobe.
- `fifo_wr_data` out 8: byte written.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at session end.
- `overflow` out 1: sticky; at least one sample dropped this session; cleared on accepted `start`.
- `captured` out COUNT_W: samples fully written this session; saturates at all-ones; holds after `done` until next accepted `start`.

## Operation
- States: IDLE, WARMUP, CAPTURE, WRITE, DONE.
- IDLE + `start`:
  - Latch `sample_count` into `target`; clear `captured` and `overflow`.
  - Go to WARMUP, or to CAPTURE if `WARMUP_SAMPLES`==0.
- WARMUP:
  - Count `pcm_valid`; those samples are discarded.
  - After the `WARMUP_SAMPLES`-th strobe, go to CAPTURE.
- CAPTURE + `pcm_valid`: load `pcm_in` into the shift register, set byte index = 0, go to WRITE.
- WRITE:
  - `fifo_wr_en` = !`fifo_full`; `fifo_wr_data` = shift register bits [DATA_W-1 -: 8].
  - On each accepted byte, shift left 8 and increment the byte index.
  - While `fifo_full`, hold; there is no timeout.
  - After the last byte (DATA_W/8 bytes), increment `captured`.
  - Go to DONE if (`target`!=0 and `captured`+1==`target`) or `stop_pending`; otherwise go to CAPTURE.
- `pcm_valid` during WRITE: the new sample is dropped and `overflow` is set. The current sample continues.
- `stop`:
  - In WARMUP or CAPTURE: go to DONE next cycle. A simultaneous `pcm_valid` is discarded.
  - In WRITE: set `stop_pending`. The current sample finishes, so the FIFO never holds a partial sample.
- DONE: `done`=1 for one cycle, clear `stop_pending`, go to IDLE.
- `start` and `stop` in the same cycle in IDLE: `start` is accepted.
- `start` while busy: ignored, with no effect on state or `overflow`.
- `rst_n` low mid-session:
  - Next edge returns to IDLE and clears all state.
  - A partially written sample stays in the FIFO; clearing it is the FIFO owner's job.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_wr_data`=0, `busy`=0, `done`=0, `overflow`=0, `captured`=0, state=IDLE.
- `start` at edge N: `busy`=1 from N+1.
- `pcm_valid` in CAPTURE at edge N, with no `fifo_full`:
  - Byte k is written at cycle N+1+k.
  - `captured` updates at N+DATA_W/8+1.
- `done` pulses one cycle after the last byte's write cycle. `busy` falls the cycle after `done`.
- `fifo_wr_en` is combinational from state and `fifo_full`. All other outputs are registered.
- Each `fifo_full` cycle during WRITE adds one cycle of latency.

## Structure
- Shared package `i2s_pkg`: `rec_state_t` enum and a `BYTES_PER_SAMPLE` helper function.
- One sub-module, `sample_serializer`:
  - Function: shift register plus byte index, with load/advance/last outputs.
  - Parameter: `DATA_W`.
- The FSM, counters and flags live in `i2s_record_ctrl`.

## Test plan
- Count stop, no warm-up, FIFO never full:
  - Stimulus: `WARMUP_SAMPLES`=0, `sample_count`=3, samples 0x1234, 0xABCD, 0x00FF.
  - Response: FIFO receives 12 34 AB CD 00 FF; `done` one cycle after the last write; `captured`=3; `overflow`=0.
- Warm-up discard:
  - Stimulus: `WARMUP_SAMPLES`=4, `sample_count`=2, samples 1..6.
  - Response: only samples 5 and 6 are written (00 05 00 06).
- Backpressure:
  - Stimulus: `fifo_full` high for 5 cycles during byte 1 of 0xBEEF.
  - Response: BE is written, then EF 6 cycles later; no data lost.
- Overflow:
  - Stimulus: `fifo_full` held high while the next `pcm_valid` arrives.
  - Response: that sample is dropped; `overflow`=1 and stays set until next `start`; `captured` excludes the dropped sample.
- Continuous mode with stop:
  - Stimulus: `sample_count`=0; `stop` asserted in the cycle after byte 0 of sample 7 is written.
  - Response: byte 1 of sample 7 is still written; `captured`=7; `done` pulses once.
- Reset and ignored commands:
  - Stimulus: `rst_n` low mid-WRITE; separately, `start` while busy.
  - Response: after reset, all outputs return to reset values and state is IDLE. `start` while busy has no effect, and `target` is unchanged.
